sample_streamer: RTL and testbench
==================================

Name: sample_streamer

Overview:
Playback sequencer directly upstream of the PWM modulator. It walks the 32-bit sample ROM and unpacks each word into four 8-bit samples. Samples are buffered in a small FIFO and released one per sample_tick, so the modulator receives a steady sample stream. It replaces the free-running address counter and its enable synchronizer with a single-clock block that has explicit underrun and end-of-clip handling.

Parameters:
ADDR_W, 32, ROM word-address width
LAST_ADDR, 1023, address of last ROM word in the clip
FIFO_DEPTH, 8, sample FIFO depth in entries (power of two, >=4)
LOOP, 1, 1 = restart at address 0 after LAST_ADDR; 0 = stop

Ports:
clk  in  1  system clock (modulator clock domain)
rst  in  1  synchronous, active-high reset
aud_en  in  1  playback enable, already synchronous to clk
sample_tick  in  1  one-cycle strobe at the sample rate, from the clock divider
rom_addr  out  ADDR_W  ROM word address
rom_data  in  32  ROM read data, combinational from rom_addr
sample_o  out  8  current sample to the modulator
sample_valid  out  1  one-cycle pulse when sample_o is updated from the FIFO
playing  out  1  high in FETCH or UNPACK
underrun  out  1  sticky underrun flag

Behaviour:
Reset:
- rst=1 at a clk edge: state=IDLE, rom_addr=0, FIFO empty, sample_o=0, sample_valid=0, underrun=0.
- Reset mid-operation aborts immediately. No partial word is kept.

FSM:
- IDLE: rom_addr=0. aud_en=1 -> FETCH.
- FETCH (1 cycle): word_reg<=rom_data, byte_idx<=0, -> UNPACK.
- UNPACK: push word_reg[8*byte_idx+7 : 8*byte_idx] into the FIFO, byte0 (bits 7:0) first.
  - If the FIFO is full, stall; byte_idx holds.
  - After the push with byte_idx=3:
    - rom_addr!=LAST_ADDR: rom_addr+1, -> FETCH.
    - rom_addr==LAST_ADDR and LOOP=1: rom_addr<=0, -> FETCH.
    - rom_addr==LAST_ADDR and LOOP=0: -> DONE.
- DONE: FIFO drains normally. aud_en=0 -> IDLE.
- aud_en=0 in FETCH/UNPACK/DONE: -> IDLE next edge. FIFO flushed, rom_addr=0, sample_o=0. underrun is kept.
- playing = (state==FETCH || state==UNPACK).

FIFO:
- Occupancy 0..FIFO_DEPTH. Full/empty are evaluated on the pre-edge count.
- Push and pop in the same cycle are both allowed (including when full or empty is false); count stays the same.
- A push is blocked while full, even if a pop occurs that cycle.

Output:
- sample_tick with FIFO non-empty: sample_o<=head, pop, sample_valid=1 for that edge only.
- sample_tick with FIFO empty and state FETCH/UNPACK: underrun<=1 (sticky until rst), sample_o holds, sample_valid=0.
- sample_tick with FIFO empty in DONE or IDLE: sample_o<=0, no underrun.
- sample_tick ignored while aud_en=0.

Latency and throughput:
- aud_en rises before edge 1 -> FETCH after edge 1, word captured at edge 2, first push at edge 3.
- First sample_valid occurs on the first tick at or after edge 4.
- Fill throughput is 4 samples per 5 cycles, so the FIFO never underruns when ticks are >=2 cycles apart after the first fill.

Arithmetic:
- rom_addr increments modulo 2^ADDR_W.
- LAST_ADDR compare is an exact equality.

Test Plan:
- ROM word n = {n*4+3, n*4+2, n*4+1, n*4} (bytes), LAST_ADDR=3, LOOP=0, tick every 16 cycles -> sample_o sequence 0x00..0x0F with 16 sample_valid pulses, then DONE, playing=0, sample_o=0 on the next tick, underrun=0.
- Same ROM, LOOP=1, LAST_ADDR=1 -> sequence 0x00..0x07 repeats and rom_addr wraps 1->0; the FIFO never underruns.
- Tick every cycle from aud_en rise -> underrun=1 on the first tick before edge 4; it stays 1 after the stream recovers and clears only on rst.
- No ticks for 40 cycles -> FIFO holds 8 samples, FSM stalls in UNPACK with byte_idx frozen; the next ticks deliver 0x00,0x01,... with nothing lost or duplicated.
- aud_en dropped mid-word (byte_idx=2) -> IDLE next edge, rom_addr=0, sample_o=0. Re-enabling restarts at sample 0x00.
- rst asserted while the FIFO holds 5 samples -> all outputs reset values next edge; with aud_en held high, playback restarts from 0x00.

Source files
------------

// File: rtl/sample_streamer.sv
// sample_streamer: unpacks 32-bit ROM words into a byte FIFO and releases one sample per sample_tick
module sample_streamer #(
   parameter int          ADDR_W     = 32,
   parameter int unsigned LAST_ADDR  = 1023,
   parameter int          FIFO_DEPTH = 8,
   parameter int          LOOP       = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              aud_en,
   input  logic              sample_tick,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [31:0]       rom_data,
   output logic [7:0]        sample_o,
   output logic              sample_valid,
   output logic              playing,
   output logic              underrun
);
   localparam int CW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, FETCH, UNPACK, DONE} state_t;
   state_t        state;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [CW-1:0] wr_ptr, rd_ptr;
   logic [CW:0]   count;
   logic [31:0]   word_reg;
   logic [1:0]    byte_idx;
   logic          full, empty, push, pop, last;
   assign full    = count == (CW+1)'(FIFO_DEPTH);
   assign empty   = count == '0;
   assign push    = aud_en && state == UNPACK && !full;
   assign pop     = aud_en && sample_tick && !empty;
   assign last    = rom_addr == ADDR_W'(LAST_ADDR);
   assign playing = state == FETCH || state == UNPACK;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= word_reg[{byte_idx, 3'b000} +: 8];
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rom_addr     <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         word_reg     <= '0;
         byte_idx     <= '0;
         sample_o     <= '0;
         sample_valid <= 1'b0;
         underrun     <= 1'b0;
      end else if (!aud_en) begin
         // disabling flushes everything except the sticky underrun flag
         state        <= IDLE;
         rom_addr     <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         byte_idx     <= '0;
         sample_o     <= '0;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= pop;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (CW+1)'(push) - (CW+1)'(pop);
         if (sample_tick) begin
            if (!empty) sample_o <= mem[rd_ptr];
            else if (playing) underrun <= 1'b1;
            else sample_o <= '0;
         end
         case (state)
            IDLE: state <= FETCH;
            FETCH: begin
               word_reg <= rom_data;
               byte_idx <= '0;
               state    <= UNPACK;
            end
            UNPACK:
               if (push) begin
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     if (!last || LOOP != 0) state <= FETCH;
                     else state <= DONE;
                     if (!last) rom_addr <= rom_addr + 1'b1;
                     else if (LOOP != 0) rom_addr <= '0;
                  end
               end
            DONE: state <= DONE;
         endcase
      end
   end
endmodule

// File: tb/tb_sample_streamer.sv
// tb_sample_streamer: directed stimulus with a queue scoreboard for two streamer configurations
module tb_sample_streamer;
   logic        clk, rst, en_a, en_b, tick_a, tick_b;
   logic [31:0] addr_a, addr_b, rom_a, rom_b;
   logic [7:0]  sample_a, sample_b;
   logic        valid_a, valid_b, playing_a, playing_b, underrun_a, underrun_b;
   typedef struct {string name; longint act; longint exp;} chk_t;
   chk_t       cq[$];
   logic [7:0] qa[$], qb[$];
   int         checks = 0, errors = 0;
   bit         fin = 0, done = 0;

   function automatic logic [31:0] word(input logic [31:0] a);
      logic [7:0] b;
      b = 8'(a * 4);
      return {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction
   assign rom_a = word(addr_a);
   assign rom_b = word(addr_b);

   sample_streamer #(.ADDR_W(32), .LAST_ADDR(3), .FIFO_DEPTH(8), .LOOP(0)) u_a (
      .clk(clk), .rst(rst), .aud_en(en_a), .sample_tick(tick_a), .rom_addr(addr_a),
      .rom_data(rom_a), .sample_o(sample_a), .sample_valid(valid_a), .playing(playing_a),
      .underrun(underrun_a));
   sample_streamer #(.ADDR_W(32), .LAST_ADDR(1), .FIFO_DEPTH(8), .LOOP(1)) u_b (
      .clk(clk), .rst(rst), .aud_en(en_b), .sample_tick(tick_b), .rom_addr(addr_b),
      .rom_data(rom_b), .sample_o(sample_b), .sample_valid(valid_b), .playing(playing_b),
      .underrun(underrun_b));

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input longint a, input longint e);
      chk_t c;
      c.name = n; c.act = a; c.exp = e;
      cq.push_back(c);
   endtask

   task automatic step(input bit ta, input bit tbv);
      tick_a = ta; tick_b = tbv;
      @(negedge clk);
      tick_a = 0; tick_b = 0;
   endtask

   // monitor: owns all counters, compares direct checks and sample pulses
   initial begin
      chk_t       c;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         while (cq.size() > 0) begin
            c = cq.pop_front();
            checks++;
            if (c.act !== c.exp) begin
               errors++;
               $display("FAIL %s: got %0h expected %0h", c.name, c.act, c.exp);
            end
         end
         if (valid_a === 1'b1) begin
            checks++;
            if (qa.size() == 0) begin
               errors++;
               $display("FAIL a_sample: got %02h expected no pulse", sample_a);
            end else begin
               e = qa.pop_front();
               if (sample_a !== e) begin
                  errors++;
                  $display("FAIL a_sample: got %02h expected %02h", sample_a, e);
               end
            end
         end
         if (valid_b === 1'b1) begin
            checks++;
            if (qb.size() == 0) begin
               errors++;
               $display("FAIL b_sample: got %02h expected no pulse", sample_b);
            end else begin
               e = qb.pop_front();
               if (sample_b !== e) begin
                  errors++;
                  $display("FAIL b_sample: got %02h expected %02h", sample_b, e);
               end
            end
         end
         if (fin && !done) begin
            checks += 2;
            if (qa.size() != 0) begin
               errors++;
               $display("FAIL a_leftover: got %0d pending expected 0", qa.size());
            end
            if (qb.size() != 0) begin
               errors++;
               $display("FAIL b_leftover: got %0d pending expected 0", qb.size());
            end
            done = 1;
         end
      end
   end

   initial begin
      int     wraps;
      longint maxa, prev;
      rst = 1; en_a = 0; en_b = 0; tick_a = 0; tick_b = 0;
      repeat (2) step(0, 0);
      chk("rst_sample_a", sample_a, 0);
      chk("rst_valid_a", valid_a, 0);
      chk("rst_playing_a", playing_a, 0);
      chk("rst_underrun_a", underrun_a, 0);
      chk("rst_addr_a", addr_a, 0);
      chk("rst_addr_b", addr_b, 0);
      rst = 0;
      // one-shot clip of 16 samples, slow ticks
      for (int n = 0; n < 16; n++) qa.push_back(8'(n));
      en_a = 1;
      for (int i = 0; i < 288; i++) step(i % 16 == 15, 0);
      chk("t1_playing", playing_a, 0);
      chk("t1_sample_zero", sample_a, 0);
      chk("t1_underrun", underrun_a, 0);
      chk("t1_addr_last", addr_a, 3);
      en_a = 0;
      step(0, 0);
      chk("t1_addr_idle", addr_a, 0);
      // looping two-word clip
      for (int r = 0; r < 5; r++) for (int n = 0; n < 8; n++) qb.push_back(8'(n));
      en_b = 1; wraps = 0; maxa = 0; prev = addr_b;
      for (int i = 0; i < 84; i++) begin
         step(0, i >= 4 && i % 2 == 0);
         if (prev == 1 && addr_b == 0) wraps++;
         if (addr_b > maxa) maxa = addr_b;
         prev = addr_b;
      end
      chk("t2_underrun", underrun_b, 0);
      chk("t2_wrap_seen", wraps > 0, 1);
      chk("t2_addr_max", maxa, 1);
      chk("t2_playing", playing_b, 1);
      en_b = 0;
      step(0, 0);
      // tick every cycle from enable
      for (int n = 0; n < 16; n++) qa.push_back(8'(n));
      en_a = 1;
      step(1, 0);
      chk("t3_underrun_e1", underrun_a, 0);
      step(1, 0);
      chk("t3_underrun_e2", underrun_a, 1);
      for (int i = 2; i < 20; i++) step(1, 0);
      for (int i = 0; i < 80; i++) step(i % 4 == 0, 0);
      chk("t3_underrun_sticky", underrun_a, 1);
      chk("t3_playing", playing_a, 0);
      en_a = 0;
      step(0, 0);
      chk("t3_underrun_kept", underrun_a, 1);
      rst = 1;
      step(0, 0);
      rst = 0;
      chk("t3_underrun_cleared", underrun_a, 0);
      // long stall with a full FIFO
      for (int n = 0; n < 16; n++) qa.push_back(8'(n));
      en_a = 1;
      repeat (40) step(0, 0);
      chk("t4_addr_stall", addr_a, 2);
      chk("t4_playing", playing_a, 1);
      for (int i = 0; i < 40; i++) step(i % 2 == 0, 0);
      chk("t4_sample_zero", sample_a, 0);
      chk("t4_underrun", underrun_a, 0);
      en_a = 0;
      step(0, 0);
      // disable mid-word, then restart
      qa.push_back(8'h00); qa.push_back(8'h01);
      en_a = 1;
      for (int i = 0; i < 9; i++) step(i == 4 || i == 5, 0);
      chk("t5_sample_pre", sample_a, 1);
      chk("t5_addr_pre", addr_a, 1);
      en_a = 0;
      step(0, 0);
      chk("t5_playing", playing_a, 0);
      chk("t5_addr", addr_a, 0);
      chk("t5_sample", sample_a, 0);
      for (int n = 0; n < 8; n++) qa.push_back(8'(n));
      en_a = 1;
      for (int i = 0; i < 20; i++) step(i >= 4 && i % 2 == 0, 0);
      en_a = 0;
      step(0, 0);
      // reset with five samples buffered, enable held
      qa.push_back(8'h00); qa.push_back(8'h01);
      en_a = 1;
      for (int i = 0; i < 10; i++) step(i == 1 || i == 3 || i == 4, 0);
      chk("t6_underrun_pre", underrun_a, 1);
      chk("t6_sample_pre", sample_a, 1);
      rst = 1;
      step(0, 0);
      rst = 0;
      chk("t6_sample", sample_a, 0);
      chk("t6_valid", valid_a, 0);
      chk("t6_playing", playing_a, 0);
      chk("t6_underrun", underrun_a, 0);
      chk("t6_addr", addr_a, 0);
      for (int n = 0; n < 8; n++) qa.push_back(8'(n));
      for (int i = 0; i < 20; i++) step(i >= 4 && i % 2 == 0, 0);
      chk("t6_underrun_after", underrun_a, 0);
      en_a = 0;
      repeat (2) step(0, 0);
      fin = 1;
      for (int k = 0; k < 10 && !done; k++) @(negedge clk);
      if (!done) begin
         $display("FAIL finish: got no monitor completion expected completion");
         $fatal(1);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
